// File: rtl/demo_timer_pkg.sv
// rtl/demo_timer_pkg.sv - register offsets, CTRL bit layout and helpers for demo_io_timer
package demo_timer_pkg;

    localparam logic [2:0] TMR_CTRL      = 3'd0;
    localparam logic [2:0] TMR_STATUS    = 3'd1;
    localparam logic [2:0] TMR_RELOAD_LO = 3'd2;
    localparam logic [2:0] TMR_RELOAD_HI = 3'd3;
    localparam logic [2:0] TMR_COUNT_LO  = 3'd4;
    localparam logic [2:0] TMR_COUNT_HI  = 3'd5;
    localparam logic [2:0] TMR_PRESCALE  = 3'd6;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    // Field order puts en at bit 0 so the packed value matches the register byte.
    typedef struct packed {
        logic ie;
        logic ar;
        logic en;
    } ctrl_t;

    function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
        return {5'b00000, c};
    endfunction

endpackage

// File: rtl/demo_timer_prescaler.sv
// rtl/demo_timer_prescaler.sv - free-running prescaler producing a one-cycle tick every period+1 enabled clocks
module demo_timer_prescaler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clear,
    input  logic [7:0] period,
    output logic       tick
);

    logic [7:0] cnt;
    logic       at_end;

    assign at_end = (cnt == period);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clear) begin
            cnt <= 8'd0;
        end else if (en) begin
            cnt <= at_end ? 8'd0 : cnt + 8'd1;
        end
    end

    assign tick = en & at_end;

endmodule

// File: rtl/demo_io_timer.sv
// rtl/demo_io_timer.sv - 16-bit down-counting interval timer with prescaler and level irq
// Optional macro DEMO_TIMER_SNAPSHOT_EN: COUNT_LO reads latch the high byte for tear-free 16-bit reads.
module demo_io_timer
    import demo_timer_pkg::*;
#(
    parameter logic [7:0]  RESET_PRESCALE = 8'd0,
    parameter logic [15:0] RESET_RELOAD   = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    input  logic       read_en,
    output logic [7:0] dout,
    output logic       irq
);

    ctrl_t       ctrl;
    logic        exp_flag;
    logic [15:0] reload;
    logic [15:0] count;
    logic [7:0]  prescale;

    logic        wr;
    logic        rd;
    logic        wr_ctrl;
    logic        wr_status;
    logic        wr_rld_lo;
    logic        wr_rld_hi;
    logic        wr_pre;
    logic        tick;
    logic        tick_eff;
    logic        expire;
    logic [7:0]  count_hi_rd;
    logic [7:0]  rd_data;

    assign wr        = cs & ~read_en;
    assign rd        = cs & read_en;
    assign wr_ctrl   = wr & (addr == TMR_CTRL);
    assign wr_status = wr & (addr == TMR_STATUS);
    assign wr_rld_lo = wr & (addr == TMR_RELOAD_LO);
    assign wr_rld_hi = wr & (addr == TMR_RELOAD_HI);
    assign wr_pre    = wr & (addr == TMR_PRESCALE);

    demo_timer_prescaler u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (ctrl.en),
        .clear  (wr_rld_hi),
        .period (prescale),
        .tick   (tick)
    );

    // A RELOAD_HI write restarts the interval, so a coincident tick is dropped.
    assign tick_eff = tick & ~wr_rld_hi;
    assign expire   = tick_eff & (count == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl.en <= din[CTRL_EN];
            ctrl.ar <= din[CTRL_AR];
            ctrl.ie <= din[CTRL_IE];
        end else if (expire & ~ctrl.ar) begin
            ctrl.en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (wr_status & din[0]) begin
            exp_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reload   <= RESET_RELOAD;
            prescale <= RESET_PRESCALE;
        end else begin
            if (wr_rld_lo) reload[7:0]  <= din;
            if (wr_rld_hi) reload[15:8] <= din;
            if (wr_pre)    prescale     <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= RESET_RELOAD;
        end else if (wr_rld_hi) begin
            count <= {din, reload[7:0]};
        end else if (tick_eff) begin
            if (count != 16'd0) begin
                count <= count - 16'd1;
            end else if (ctrl.ar) begin
                count <= reload;
            end
        end
    end

`ifdef DEMO_TIMER_SNAPSHOT_EN
    logic [7:0] snapshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= 8'd0;
        end else if (rd & (addr == TMR_COUNT_LO)) begin
            snapshot <= count[15:8];
        end
    end

    assign count_hi_rd = snapshot;
`else
    assign count_hi_rd = count[15:8];
`endif

    always_comb begin
        rd_data = 8'd0;
        case (addr)
            TMR_CTRL:      rd_data = ctrl_to_byte(ctrl);
            TMR_STATUS:    rd_data = {7'd0, exp_flag};
            TMR_RELOAD_LO: rd_data = reload[7:0];
            TMR_RELOAD_HI: rd_data = reload[15:8];
            TMR_COUNT_LO:  rd_data = count[7:0];
            TMR_COUNT_HI:  rd_data = count_hi_rd;
            TMR_PRESCALE:  rd_data = prescale;
            default:       rd_data = 8'd0;
        endcase
    end

    // Registered like the sync RAM/ROM so the decoder mux needs no special case.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= 8'd0;
        end else if (rd) begin
            dout <= rd_data;
        end
    end

    assign irq = exp_flag & ctrl.ie;

endmodule

// File: tb/tb_demo_io_timer.sv
// tb/tb_demo_io_timer.sv - directed and randomized checks of demo_io_timer against a behavioural model
module tb_demo_io_timer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b0;
    logic [2:0] addr = 3'd0;
    logic [7:0] din = 8'd0;
    logic       read_en = 1'b1;
    logic [7:0] dout;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    demo_io_timer dut (
        .clk     (clk),
        .rst     (rst),
        .cs      (cs),
        .addr    (addr),
        .din     (din),
        .read_en (read_en),
        .dout    (dout),
        .irq     (irq)
    );

    // Behavioural model state
    logic        m_en, m_ar, m_ie, m_exp;
    logic [15:0] m_reload, m_count;
    logic [7:0]  m_pre, m_pcnt, m_snap, m_dout;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {5'd0, m_ie, m_ar, m_en};
            3'd1: return {7'd0, m_exp};
            3'd2: return m_reload[7:0];
            3'd3: return m_reload[15:8];
            3'd4: return m_count[7:0];
`ifdef DEMO_TIMER_SNAPSHOT_EN
            3'd5: return m_snap;
`else
            3'd5: return m_count[15:8];
`endif
            3'd6: return m_pre;
            default: return 8'd0;
        endcase
    endfunction

    function automatic bit m_tick_due();
        return m_en && (m_pcnt == m_pre);
    endfunction

    task automatic model_clock(input logic c, input logic [2:0] a, input logic [7:0] d, input logic r);
        logic wr, rd, load, tick, expire;
        if (rst) begin
            {m_en, m_ar, m_ie, m_exp} = 4'b0000;
            m_reload = 16'hFFFF;
            m_count  = 16'hFFFF;
            m_pre    = 8'd0;
            m_pcnt   = 8'd0;
            m_snap   = 8'd0;
            m_dout   = 8'd0;
        end else begin
            wr     = c && !r;
            rd     = c && r;
            load   = wr && (a == 3'd3);
            tick   = m_tick_due() && !load;
            expire = tick && (m_count == 16'd0);
            if (rd) begin
                m_dout = m_read(a);
                if (a == 3'd4) m_snap = m_count[15:8];
            end
            if (load)      m_pcnt = 8'd0;
            else if (m_en) m_pcnt = (m_pcnt == m_pre) ? 8'd0 : m_pcnt + 8'd1;
            if (load)                 m_count = {d, m_reload[7:0]};
            else if (tick && m_count != 16'd0) m_count = m_count - 16'd1;
            else if (tick)            m_count = m_ar ? m_reload : 16'd0;
            if (expire)                           m_exp = 1'b1;
            else if (wr && a == 3'd1 && d[0])     m_exp = 1'b0;
            if (wr && a == 3'd0)         {m_ie, m_ar, m_en} = d[2:0];
            else if (expire && !m_ar)    m_en = 1'b0;
            if (wr && a == 3'd2) m_reload[7:0]  = d;
            if (load)            m_reload[15:8] = d;
            if (wr && a == 3'd6) m_pre = d;
        end
    endtask

    task automatic step(input logic c, input logic [2:0] a, input logic [7:0] d, input logic r);
        cs = c; addr = a; din = d; read_en = r;
        @(posedge clk);
        model_clock(c, a, d, r);
        #1;
        chk("dout_model", {8'h00, dout}, {8'h00, m_dout});
        chk("irq_model", {15'd0, irq}, {15'd0, m_exp & m_ie});
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        step(1'b1, a, d, 1'b0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, a, 8'h00, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 8'h00, 1'b1);
    endtask

    task automatic reset_reads(input string tag);
        logic [7:0] rv [8];
        rv = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            chk($sformatf("%s_rd%0d", tag, i), {8'h00, dout}, {8'h00, rv[i]});
        end
        chk({tag, "_irq"}, {15'd0, irq}, 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int i;
        rst = 1'b1;
        idle();
        idle();
        rst = 1'b0;
        reset_reads("reset");

        // One-shot, prescale 0, count 3
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h03);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h05);
        idle(); idle(); idle();
        chk("oneshot_irq_early", {15'd0, irq}, 16'd0);
        idle();
        chk("oneshot_irq_at4", {15'd0, irq}, 16'd1);
        rd(3'd4);
        chk("oneshot_count", {8'h00, dout}, 16'h0000);
        rd(3'd0);
        chk("oneshot_ctrl", {8'h00, dout}, 16'h0004);
        wr(3'd1, 8'h01);
        chk("oneshot_w1c_irq", {15'd0, irq}, 16'd0);

        // Auto-reload with prescale 1: period 6
        wr(3'd6, 8'h01);
        wr(3'd2, 8'h02);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h03);
        for (int k = 0; k < 5; k++) idle();
        rd(3'd1);
        chk("ar_exp_before", {8'h00, dout}, 16'h0000);
        rd(3'd1);
        chk("ar_exp_first", {8'h00, dout}, 16'h0001);
        wr(3'd1, 8'h01);
        idle(); idle(); idle();
        rd(3'd1);
        chk("ar_exp_cleared", {8'h00, dout}, 16'h0000);
        rd(3'd1);
        chk("ar_exp_second", {8'h00, dout}, 16'h0001);
        chk("ar_irq_masked", {15'd0, irq}, 16'd0);
        wr(3'd1, 8'h00);
        rd(3'd1);
        chk("ar_w0_noeffect", {8'h00, dout}, 16'h0001);
        wr(3'd1, 8'h01);

        // W1C landing on the expiring edge
        i = 0;
        while (!(m_tick_due() && m_count == 16'd0) && i < 50) begin idle(); i++; end
        chk("collide_clr_reached", {15'd0, m_tick_due() && m_count == 16'd0}, 16'd1);
        wr(3'd1, 8'h01);
        rd(3'd1);
        chk("collide_clr_exp", {8'h00, dout}, 16'h0001);

        // RELOAD_HI write on a tick edge
        i = 0;
        while (!(m_tick_due() && m_count != 16'd0) && i < 50) begin idle(); i++; end
        chk("collide_rld_reached", {15'd0, m_tick_due() && m_count != 16'd0}, 16'd1);
        wr(3'd3, 8'h12);
        rd(3'd4);
        chk("collide_rld_lo", {8'h00, dout}, 16'h0002);
        rd(3'd5);
        chk("collide_rld_hi", {8'h00, dout}, 16'h0012);

        // Read COUNT across the 0x0100 -> 0x00FF boundary
        wr(3'd0, 8'h00);
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        wr(3'd0, 8'h01);
        rd(3'd4);
        chk("snap_lo", {8'h00, dout}, 16'h0000);
        rd(3'd5);
`ifdef DEMO_TIMER_SNAPSHOT_EN
        chk("snap_hi", {8'h00, dout}, 16'h0001);
`else
        chk("live_hi", {8'h00, dout}, 16'h0000);
`endif

        // Randomized traffic, small periods so expiries happen often
        for (int k = 0; k < 400; k++) begin
            logic       c, r;
            logic [2:0] a;
            logic [7:0] d;
            c = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 1) == 1;
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            if (a == 3'd6) d = 8'($urandom_range(0, 3));
            if (a == 3'd3) d = 8'($urandom_range(0, 1));
            if (a == 3'd2) d = 8'($urandom_range(0, 15));
            step(c, a, d, r);
        end

        // Reset in the middle of a count with irq enabled
        wr(3'd6, 8'h00);
        wr(3'd2, 8'h05);
        wr(3'd3, 8'h00);
        wr(3'd0, 8'h07);
        idle(); idle();
        rd(3'd4);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("midrst_dout", {8'h00, dout}, 16'h0000);
        reset_reads("midrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
